missile_controller: RTL and testbench

MISSILE_CONTROLLER -- requirements
Module: missile_controller

---
 rtl/missile_controller.sv | 142 ++++++++++++++
 tb/tb_missile_controller.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/missile_controller.sv
// Missile launch/flight/cooldown controller with a registered bounding-box hit test for the renderer.
// Optional feature: define MISSILE_COOLDOWN_EN to block relaunch for COOLDOWN_FRAMES frames after a flight ends.
module missile_controller #(
    parameter int SPEED           = 4,
    parameter int COOLDOWN_FRAMES = 30,
    parameter int OBJ_SIZE        = 25,
    parameter int X_MAX           = 639,
    parameter int Y_MAX           = 479
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        fireReq,
    input  logic [10:0] tankX,
    input  logic [10:0] tankY,
    input  logic [1:0]  tankDir,
    input  logic        collision,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    output logic        fireAck,
    output logic        active,
    output logic [10:0] missileX,
    output logic [10:0] missileY,
    output logic [10:0] offsetX,
    output logic [10:0] offsetY,
    output logic        InsideRectangle
);

    localparam logic [10:0] SPD   = 11'(SPEED);
    localparam logic [11:0] X_LIM = 12'(X_MAX + 1);
    localparam logic [11:0] Y_LIM = 12'(Y_MAX + 1);

    if (COOLDOWN_FRAMES < 1) begin : g_bad_cfg
        $error("COOLDOWN_FRAMES must be at least 1");
    end

`ifdef MISSILE_COOLDOWN_EN
    typedef enum logic [1:0] {IDLE = 2'd0, FLYING = 2'd1, COOLDOWN = 2'd2} state_t;
    localparam state_t END_STATE = COOLDOWN;
    localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
    logic [CW-1:0] cd_cnt;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, FLYING = 2'd1} state_t;
    localparam state_t END_STATE = IDLE;
`endif

    state_t      state, next_state;
    logic [1:0]  dir;
    logic [10:0] next_x, next_y;
    logic        launch, hit_edge, inside_c;

    // Sums are widened by one bit so the edge test cannot wrap near 2047.
    always_comb begin
        hit_edge = 1'b0;
        case (dir)
            2'd0:    hit_edge = missileY < SPD;
            2'd1:    hit_edge = ({1'b0, missileX} + 12'(OBJ_SIZE + SPEED)) > X_LIM;
            2'd2:    hit_edge = ({1'b0, missileY} + 12'(OBJ_SIZE + SPEED)) > Y_LIM;
            default: hit_edge = missileX < SPD;
        endcase
    end

    always_comb begin
        next_state = state;
        next_x     = missileX;
        next_y     = missileY;
        launch     = 1'b0;
        case (state)
            IDLE: if (fireReq) begin
                launch     = 1'b1;
                next_state = FLYING;
                next_x     = tankX;
                next_y     = tankY;
            end
            FLYING: begin
                if (collision || (startOfFrame && hit_edge)) begin
                    next_state = END_STATE;
                end else if (startOfFrame) begin
                    case (dir)
                        2'd0:    next_y = missileY - SPD;
                        2'd1:    next_x = missileX + SPD;
                        2'd2:    next_y = missileY + SPD;
                        default: next_x = missileX - SPD;
                    endcase
                end
            end
`ifdef MISSILE_COOLDOWN_EN
            COOLDOWN: if (startOfFrame && cd_cnt == CW'(COOLDOWN_FRAMES - 1)) next_state = IDLE;
`endif
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            dir      <= 2'd0;
            missileX <= '0;
            missileY <= '0;
            fireAck  <= 1'b0;
        end else begin
            state    <= next_state;
            missileX <= next_x;
            missileY <= next_y;
            fireAck  <= launch;
            if (launch) dir <= tankDir;
        end
    end

`ifdef MISSILE_COOLDOWN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cd_cnt <= '0;
        else if (state != COOLDOWN)
            cd_cnt <= '0;
        else if (startOfFrame)
            cd_cnt <= (cd_cnt == CW'(COOLDOWN_FRAMES - 1)) ? '0 : cd_cnt + 1'b1;
    end
`endif

    assign active = (state == FLYING);

    always_comb begin
        inside_c = active
            && pixelX >= missileX && {1'b0, pixelX} < ({1'b0, missileX} + 12'(OBJ_SIZE))
            && pixelY >= missileY && {1'b0, pixelY} < ({1'b0, missileY} + 12'(OBJ_SIZE));
    end

    // Subtraction only happens once inside_c guarantees pixel >= missile.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            InsideRectangle <= 1'b0;
            offsetX         <= '0;
            offsetY         <= '0;
        end else begin
            InsideRectangle <= inside_c;
            offsetX         <= inside_c ? pixelX - missileX : '0;
            offsetY         <= inside_c ? pixelY - missileY : '0;
        end
    end

endmodule

// File: tb/tb_missile_controller.sv
// Directed bench for missile_controller: launch, flight, screen edges, collision, hit box, cooldown, async reset.
module tb_missile_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startOfFrame = 1'b0;
    logic        fireReq = 1'b0;
    logic [10:0] tankX = '0, tankY = '0;
    logic [1:0]  tankDir = '0;
    logic        collision = 1'b0;
    logic [10:0] pixelX = '0, pixelY = '0;
    logic        fireAck, active, InsideRectangle;
    logic [10:0] missileX, missileY, offsetX, offsetY;

    int n_pass = 0;
    int n_tot  = 0;

    missile_controller dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .fireReq(fireReq),
        .tankX(tankX), .tankY(tankY), .tankDir(tankDir), .collision(collision),
        .pixelX(pixelX), .pixelY(pixelY), .fireAck(fireAck), .active(active),
        .missileX(missileX), .missileY(missileY), .offsetX(offsetX), .offsetY(offsetY),
        .InsideRectangle(InsideRectangle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_tot++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sof();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
    endtask

    // Reset pulse entirely between clock edges, then a single launch.
    task automatic relaunch(input int x, input int y, input int d);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tankX = 11'(x); tankY = 11'(y); tankDir = 2'(d);
        fireReq = 1'b1;
        tick();
        fireReq = 1'b0;
    endtask

    initial begin
        #1;
        tick(); tick();
        chk("rst_active", active, 0);
        chk("rst_ack", fireAck, 0);
        chk("rst_mx", missileX, 0);
        chk("rst_my", missileY, 0);
        chk("rst_inside", InsideRectangle, 0);
        chk("rst_offx", offsetX, 0);

        // Launch up from (100,200), three frames -> y=188
        relaunch(100, 200, 0);
        chk("launch_ack", fireAck, 1);
        chk("launch_active", active, 1);
        chk("launch_mx", missileX, 100);
        chk("launch_my", missileY, 200);
        fireReq = 1'b1;
        tick();
        chk("ack_one_cycle", fireAck, 0);
        chk("fly_ignore_fire", missileX, 100);
        fireReq = 1'b0;
        repeat (3) sof();
        chk("up3_my", missileY, 188);
        chk("up3_mx", missileX, 100);
        chk("up3_active", active, 1);

        // Hit box at (100,100)
        relaunch(100, 100, 0);
        pixelX = 110; pixelY = 105;
        tick();
        chk("in_flag", InsideRectangle, 1);
        chk("in_offx", offsetX, 10);
        chk("in_offy", offsetY, 5);
        pixelX = 125;
        tick();
        chk("out_flag", InsideRectangle, 0);
        chk("out_offx", offsetX, 0);
        chk("out_offy", offsetY, 0);
        pixelX = 124; pixelY = 124;
        tick();
        chk("corner_flag", InsideRectangle, 1);
        chk("corner_offx", offsetX, 24);
        chk("corner_offy", offsetY, 24);
        pixelX = 99; pixelY = 110;
        tick();
        chk("left_out", InsideRectangle, 0);

        // Right edge
        relaunch(612, 50, 1);
        sof();
        chk("right_end_active", active, 0);
        chk("right_end_mx", missileX, 612);
        relaunch(611, 50, 1);
        sof();
        chk("right_ok_active", active, 1);
        chk("right_ok_mx", missileX, 615);

        // Top edge: 4 moves to 0, then 0 ends
        relaunch(100, 4, 0);
        sof();
        chk("top_ok_my", missileY, 0);
        chk("top_ok_active", active, 1);
        sof();
        chk("top_end_active", active, 0);
        chk("top_end_my", missileY, 0);

        // Left edge
        relaunch(3, 100, 3);
        sof();
        chk("left_end_active", active, 0);
        chk("left_end_mx", missileX, 3);
        relaunch(8, 100, 3);
        sof();
        chk("left_ok_mx", missileX, 4);

        // Bottom edge: 451 moves to 455, then ends
        relaunch(100, 451, 2);
        sof();
        chk("bot_ok_my", missileY, 455);
        sof();
        chk("bot_end_active", active, 0);
        chk("bot_end_my", missileY, 455);

        // Collision coinciding with a frame tick
        relaunch(300, 300, 1);
        collision = 1'b1; startOfFrame = 1'b1;
        tick();
        collision = 1'b0; startOfFrame = 1'b0;
        chk("coll_active", active, 0);
        chk("coll_mx", missileX, 300);
        chk("coll_my", missileY, 300);

        // Relaunch with fireReq held through a collision-ended flight
        relaunch(200, 200, 2);
        fireReq = 1'b1;
        tick();
        collision = 1'b1;
        tick();
        collision = 1'b0;
        chk("end_active", active, 0);
        chk("end_ack", fireAck, 0);
`ifdef MISSILE_COOLDOWN_EN
        begin
            int acks = 0;
            for (int i = 0; i < 29; i++) begin
                startOfFrame = 1'b1;
                tick();
                acks += int'(fireAck);
                startOfFrame = 1'b0;
                tick();
                acks += int'(fireAck);
            end
            chk("cd_no_ack", acks, 0);
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            chk("cd_30_ack", fireAck, 0);
            tick();
            chk("cd_relaunch_ack", fireAck, 1);
        end
`else
        tick();
        chk("relaunch_ack", fireAck, 1);
        chk("relaunch_active", active, 1);
`endif
        fireReq = 1'b0;

        // Asynchronous reset mid-flight with the hit box lit
        relaunch(100, 100, 1);
        pixelX = 105; pixelY = 105;
        tick();
        chk("pre_rst_inside", InsideRectangle, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_active", active, 0);
        chk("arst_mx", missileX, 0);
        chk("arst_my", missileY, 0);
        chk("arst_inside", InsideRectangle, 0);
        chk("arst_offx", offsetX, 0);
        chk("arst_offy", offsetY, 0);
        tick();
        chk("arst_hold_active", active, 0);
        reset = 1'b0;
        fireReq = 1'b1;
        tick();
        fireReq = 1'b0;
        chk("post_rst_ack", fireAck, 1);
        chk("post_rst_active", active, 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
